// File: rtl/bus_slave_port.sv
// Slave-side port of the serial system bus: shifts in an LSB-first address and
// write byte, or returns an LSB-first read byte from a local memory.
module bus_slave_port #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 4096,
  parameter int READ_LAT  = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sel,
  input  logic mode,
  input  logic s_valid,
  input  logic s_in,
  output logic s_out,
  output logic s_out_valid,
  output logic ready
);

  localparam int MX1   = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int MX    = (MX1 > READ_LAT) ? MX1 : READ_LAT;
  localparam int CNT_W = $clog2(MX + 1);

  localparam logic [CNT_W-1:0] C_ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] C_DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] C_LAT_LAST  = CNT_W'(READ_LAT - 1);
  localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, WRITE, RLAT, RDATA} state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_mode;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic [DATA_W-1:0]   r_sh;
  logic [DATA_W-1:0]   mem [MEM_DEPTH];

  logic w_mode_ld, w_addr_sh, w_data_sh, w_we, w_rd_ld, w_rd_sh;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mode_ld   = 1'b0;
    w_addr_sh   = 1'b0;
    w_data_sh   = 1'b0;
    w_we        = 1'b0;
    w_rd_ld     = 1'b0;
    w_rd_sh     = 1'b0;
    case (r_state)
      IDLE: begin
        if (sel && s_valid) begin
          w_state_nxt = ADDR;
          w_cnt_nxt   = C_ONE;
          w_mode_ld   = 1'b1;
          w_addr_sh   = 1'b1;
        end
      end
      ADDR: begin
        if (!sel) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (s_valid) begin
          w_addr_sh = 1'b1;
          if (r_cnt == C_ADDR_LAST) begin
            w_state_nxt = r_mode ? RLAT : WDATA;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + C_ONE;
          end
        end
      end
      WDATA: begin
        if (!sel) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (s_valid) begin
          w_data_sh = 1'b1;
          if (r_cnt == C_DATA_LAST) begin
            w_state_nxt = WRITE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + C_ONE;
          end
        end
      end
      WRITE: begin
        // An abort landing on the commit cycle still drops the write.
        w_state_nxt = IDLE;
        w_we        = sel;
      end
      RLAT: begin
        if (!sel) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_rd_ld = (r_cnt == '0);
          if (r_cnt == C_LAT_LAST) begin
            w_state_nxt = RDATA;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + C_ONE;
          end
        end
      end
      RDATA: begin
        // Transmission runs to completion regardless of sel.
        w_rd_sh = 1'b1;
        if (r_cnt == C_DATA_LAST) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + C_ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      if (w_mode_ld) r_mode <= mode;
      if (w_addr_sh) r_addr <= {s_in, r_addr[ADDR_W-1:1]};
      if (w_data_sh) r_data <= {s_in, r_data[DATA_W-1:1]};
    end
  end

  // Memory and read shifter are not reset; contents survive a reset.
  always_ff @(posedge clk) begin
    if (w_we) mem[r_addr] <= r_data;
    if (w_rd_ld)      r_sh <= mem[r_addr];
    else if (w_rd_sh) r_sh <= {1'b0, r_sh[DATA_W-1:1]};
  end

  assign ready       = (r_state == IDLE);
  assign s_out_valid = (r_state == RDATA);
  assign s_out       = s_out_valid & r_sh[0];

endmodule

// File: tb/tb_bus_slave_port.sv
// Directed bench for bus_slave_port: frame drivers build the expected per-cycle
// ready/valid/data timeline from a byte-level memory model.
module tb_bus_slave_port;

  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 8;
  localparam int READ_LAT = 2;

  logic clk, reset, sel, mode, s_valid, s_in;
  logic s_out, s_out_valid, ready;

  logic exp_ready, exp_vld, exp_out;
  logic smp;
  int   n_chk, n_fail;
  logic [7:0] mm [int];
  logic [7:0] got;

  bus_slave_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(4096), .READ_LAT(READ_LAT)) dut (
    .clk(clk), .reset(reset), .sel(sel), .mode(mode), .s_valid(s_valid), .s_in(s_in),
    .s_out(s_out), .s_out_valid(s_out_valid), .ready(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("ready", {7'd0, ready}, {7'd0, exp_ready});
    chk("s_out_valid", {7'd0, s_out_valid}, {7'd0, exp_vld});
    if (reset)        chk("s_out_rst", {7'd0, s_out}, 8'd0);
    else if (exp_vld) chk("s_out", {7'd0, s_out}, {7'd0, exp_out});
  end

  task automatic step(input logic s, m, v, b, er, ev, eo);
    sel = s; mode = m; s_valid = v; s_in = b;
    exp_ready = er; exp_vld = ev; exp_out = eo;
    @(negedge clk);
    smp = s_out;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1, 0, 0);
  endtask

  // Address phase; optional s_valid gap of glen cycles after bit gat.
  task automatic send_addr(input logic m, input logic [11:0] a, input int gat, input int glen);
    step(1, m, 1, a[0], 1, 0, 0);
    for (int i = 1; i < ADDR_W; i++) begin
      if (i - 1 == gat)
        for (int g = 0; g < glen; g++) step(1, 0, 0, 1'($urandom), 0, 0, 0);
      step(1, 0, 1, a[i], 0, 0, 0);
    end
  endtask

  task automatic wr(input logic [11:0] a, input logic [7:0] d, input int gat, input int glen);
    send_addr(0, a, gat, glen);
    for (int i = 0; i < DATA_W; i++) step(1, 0, 1, d[i], 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    mm[int'(a)] = d;
  endtask

  task automatic wr_abort(input logic [11:0] a, input logic [7:0] d, input int nbits);
    send_addr(0, a, -1, 0);
    for (int i = 0; i < nbits; i++) step(1, 0, 1, d[i], 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rd(input logic [11:0] a, output logic [7:0] b);
    logic [7:0] e;
    e = mm.exists(int'(a)) ? mm[int'(a)] : 8'h00;
    b = 8'h00;
    send_addr(1, a, -1, 0);
    for (int i = 0; i < READ_LAT; i++) step(1, 0, 0, 1'($urandom), 0, 0, 0);
    for (int i = 0; i < DATA_W; i++) begin
      step(1, 0, 0, 1'($urandom), 0, 1, e[i]);
      b[i] = smp;
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    reset = 1; sel = 0; mode = 0; s_valid = 0; s_in = 0;
    exp_ready = 1; exp_vld = 0; exp_out = 0;
    @(posedge clk); #1;
    idle(2);
    reset = 0;
    idle(2);

    // Reset in the middle of an address shift.
    step(1, 0, 1, 1, 1, 0, 0);
    for (int i = 1; i < 5; i++) step(1, 0, 1, 0, 0, 0, 0);
    reset = 1;
    idle(2);
    reset = 0;
    idle(1);

    wr(12'd1001, 8'd101, -1, 0);
    rd(12'd1001, got);
    chk("rd1001_a", got, 8'h65);
    idle(1);

    // Back-to-back overwrite and second address.
    wr(12'd1001, 8'd102, -1, 0);
    wr(12'd1002, 8'd7, -1, 0);
    rd(12'd1001, got);
    chk("rd1001_b", got, 8'd102);
    rd(12'd1002, got);
    chk("rd1002", got, 8'd7);
    idle(1);

    // Address extremes, checked for aliasing.
    wr(12'd4095, 8'hFF, -1, 0);
    wr(12'd0, 8'h00, -1, 0);
    rd(12'd4095, got);
    chk("rd4095", got, 8'hFF);
    rd(12'd0, got);
    chk("rd0", got, 8'h00);
    idle(1);

    // s_valid gap after address bit 5.
    wr(12'd1500, 8'hA5, 5, 3);
    rd(12'd1500, got);
    chk("rd1500_gap", got, 8'hA5);
    idle(1);

    // Abort mid-data leaves old contents.
    wr(12'd1001, 8'd101, -1, 0);
    wr_abort(12'd1001, 8'h3C, 4);
    idle(1);
    rd(12'd1001, got);
    chk("rd1001_abort", got, 8'h65);

    // A few more patterns.
    wr(12'h555, 8'h5A, -1, 0);
    wr(12'hAAA, 8'hC3, -1, 0);
    rd(12'hAAA, got);
    chk("rdAAA", got, 8'hC3);
    rd(12'h555, got);
    chk("rd555", got, 8'h5A);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
